// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI command queue and its bench.
package spi_pkg;

  localparam int unsigned WORD_W      = 10;
  localparam int unsigned PWR_BIT     = 9;
  localparam int unsigned DC_BIT      = 8;
  localparam int unsigned DATA_MSB    = 7;
  localparam int unsigned FRAME_LEN   = 451;
  localparam int unsigned DEF_TIMEOUT = 1023;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_LOW  = 2'd2,
    ST_WAIT_HIGH = 2'd3
  } state_e;

  typedef struct packed {
    logic                pwr;
    logic                dc;
    logic [DATA_MSB:0]   data;
  } spi_word_t;

endpackage

// File: rtl/spi_fifo.sv
// Generic synchronous FIFO with registered occupancy and a combinational head.
module spi_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           head_c,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full_c,
  output logic                       empty_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             push_c, pop_c;

  assign full_c  = (level_q == LW'(DEPTH));
  assign empty_c = (level_q == '0);
  assign push_c  = wr_en && !full_c;
  assign pop_c   = rd_en && !empty_c;
  assign head_c  = mem_q[rd_ptr_q];
  assign level   = level_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q + LW'(push_c) - LW'(pop_c);
    if (push_c) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + AW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/spi_cmd_queue.sv
// Buffers CPU-written SPI words and issues them one at a time, paced on the
// driver's chip-select, with sticky overflow and timeout flags.
module spi_cmd_queue
  import spi_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WORD_W-1:0]        wr_data,
  input  logic                     clr,
  input  logic                     spi_cs_n,
  output logic                     spi_start,
  output logic [WORD_W-1:0]        spi_din,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty,
  output logic                     full,
  output logic                     busy,
  output logic                     overflow,
  output logic                     timeout
);

  localparam int unsigned TW = $clog2(TIMEOUT);

  state_e              state_q, state_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic                spi_start_q, spi_start_d;
  logic [WORD_W-1:0]   spi_din_q, spi_din_d;
  logic                overflow_q, overflow_d;
  logic                timeout_q, timeout_d;
  logic                pop_c;
  logic [WORD_W-1:0]   head_c;
  logic                fifo_full_c, fifo_empty_c;
  logic                timer_exp_c;

  spi_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (pop_c),
    .head_c  (head_c),
    .level   (level),
    .full_c  (fifo_full_c),
    .empty_c (fifo_empty_c)
  );

  assign timer_exp_c = (timer_q == TW'(TIMEOUT - 1));

  // Next-state, pop control, timer and sticky flags; set beats clr.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    spi_start_d = 1'b0;
    spi_din_d   = spi_din_q;
    pop_c       = 1'b0;
    overflow_d  = overflow_q;
    timeout_d   = timeout_q;

    if (clr) begin
      overflow_d = 1'b0;
      timeout_d  = 1'b0;
    end
    if (wr_en && fifo_full_c) overflow_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_c) begin
          pop_c       = 1'b1;
          spi_din_d   = head_c;
          spi_start_d = 1'b1;
          timer_d     = '0;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = spi_din_q[PWR_BIT] ? ST_IDLE : ST_WAIT_LOW;
      end
      ST_WAIT_LOW: begin
        if (timer_exp_c) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
          if (!spi_cs_n) state_d = ST_WAIT_HIGH;
        end
      end
      ST_WAIT_HIGH: begin
        if (timer_exp_c) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
          if (spi_cs_n) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      spi_start_q <= 1'b0;
      spi_din_q   <= '0;
      overflow_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      spi_start_q <= spi_start_d;
      spi_din_q   <= spi_din_d;
      overflow_q  <= overflow_d;
      timeout_q   <= timeout_d;
    end
  end

  assign spi_start = spi_start_q;
  assign spi_din   = spi_din_q;
  assign overflow  = overflow_q;
  assign timeout   = timeout_q;
  assign empty     = fifo_empty_c;
  assign full      = fifo_full_c;
  assign busy      = (state_q != ST_IDLE) || !fifo_empty_c;

endmodule

// File: tb/tb_spi_cmd_queue.sv
// Directed bench for spi_cmd_queue with a behavioural SPI driver chip-select model.
module tb_spi_cmd_queue;
  import spi_pkg::*;

  localparam int unsigned DEPTH   = 16;
  localparam int unsigned TIMEOUT = 1023;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [9:0]  wr_data;
  logic        clr;
  logic        spi_cs_n = 1'b1;
  logic        spi_start;
  logic [9:0]  spi_din;
  logic [4:0]  level;
  logic        empty, full, busy, overflow, timeout;

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_start = 0;
  int          cs_low = 0;
  logic [9:0]  log_q [$];

  logic        drv_en = 1'b0;
  logic        drv_pend = 1'b0;
  int unsigned drv_cnt = 0;

  spi_cmd_queue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .clr(clr),
    .spi_cs_n(spi_cs_n), .spi_start(spi_start), .spi_din(spi_din),
    .level(level), .empty(empty), .full(full), .busy(busy),
    .overflow(overflow), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Driver model: CS low one cycle after it samples start, for FRAME_LEN cycles.
  always @(posedge clk) begin
    if (!drv_en) begin
      spi_cs_n <= 1'b1;
      drv_pend <= 1'b0;
      drv_cnt  <= 0;
    end else begin
      drv_pend <= spi_start && !spi_din[PWR_BIT];
      if (drv_pend) begin
        spi_cs_n <= 1'b0;
        drv_cnt  <= FRAME_LEN;
      end else if (drv_cnt != 0) begin
        drv_cnt <= drv_cnt - 1;
        if (drv_cnt == 1) spi_cs_n <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (spi_start) begin
      n_start = n_start + 1;
      log_q.push_back(spi_din);
    end
    if (!spi_cs_n) cs_low = cs_low + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    @(posedge clk);
    n_start = 0;
    cs_low  = 0;
    log_q.delete();
    @(negedge clk);
  endtask

  task automatic push(input logic [9:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k = 0;
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(busy), 32'(0));
  endtask

  task automatic wait_cs(input logic lvl, input string tag);
    int k = 0;
    while (spi_cs_n !== lvl && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(spi_cs_n), 32'(lvl));
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  function automatic logic [31:0] log_at(input int idx);
    if (idx < log_q.size()) return 32'(log_q[idx]);
    return 32'hDEAD;
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_start"}, 32'(spi_start), 32'(0));
    check({tag, "_din"},   32'(spi_din),   32'(0));
    check({tag, "_level"}, 32'(level),     32'(0));
    check({tag, "_empty"}, 32'(empty),     32'(1));
    check({tag, "_full"},  32'(full),      32'(0));
    check({tag, "_busy"},  32'(busy),      32'(0));
    check({tag, "_ovf"},   32'(overflow),  32'(0));
    check({tag, "_tmo"},   32'(timeout),   32'(0));
  endtask

  initial begin
    int k;
    reset   = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    clr     = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    reset  = 1'b1;
    drv_en = 1'b1;
    @(negedge clk);

    // Single data word through a full frame
    clear_mon();
    push(10'h1A5);
    check("single_level1", 32'(level), 32'(1));
    check("single_nostart", 32'(spi_start), 32'(0));
    @(negedge clk);
    check("single_start", 32'(spi_start), 32'(1));
    check("single_din", 32'(spi_din), 32'h1A5);
    check("single_level0", 32'(level), 32'(0));
    wait_idle(2000, "single_idle");
    check("single_nstart", 32'(n_start), 32'(1));
    check("single_cslow", 32'(cs_low), 32'(FRAME_LEN));
    check("single_empty", 32'(empty), 32'(1));

    // Burst of 20 while the FSM is held in a frame
    clear_mon();
    push(10'h0FF);
    wait_cs(1'b0, "burst_cs_low");
    for (int i = 0; i < 20; i++) begin
      wr_en   = 1'b1;
      wr_data = 10'(i);
      @(negedge clk);
      if (i == 14) check("burst_notfull", 32'(full), 32'(0));
      if (i == 15) begin
        check("burst_full", 32'(full), 32'(1));
        check("burst_level16", 32'(level), 32'(16));
      end
    end
    wr_en = 1'b0;
    check("burst_ovf", 32'(overflow), 32'(1));
    check("burst_level_hold", 32'(level), 32'(16));
    wait_idle(20000, "burst_idle");
    check("burst_nstart", 32'(n_start), 32'(17));
    check("burst_first", log_at(0), 32'h0FF);
    for (int j = 0; j < 16; j++) check($sformatf("burst_word%0d", j), log_at(j + 1), 32'(j));
    pulse_clr();
    check("burst_clr_ovf", 32'(overflow), 32'(0));

    // Power-on words interleaved with a data word
    clear_mon();
    push(10'h200);
    push(10'h0AF);
    push(10'h200);
    wait_idle(2000, "pwr_idle");
    check("pwr_nstart", 32'(n_start), 32'(3));
    check("pwr_cslow", 32'(cs_low), 32'(FRAME_LEN));
    check("pwr_w0", log_at(0), 32'h200);
    check("pwr_w1", log_at(1), 32'h0AF);
    check("pwr_w2", log_at(2), 32'h200);

    // Timeout with the driver disconnected
    drv_en = 1'b0;
    @(negedge clk);
    clear_mon();
    push(10'h055);
    k = 0;
    while (!timeout && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("tmo_cycles", 32'(k), 32'(TIMEOUT + 2));
    check("tmo_busy", 32'(busy), 32'(0));
    check("tmo_nstart", 32'(n_start), 32'(1));
    drv_en = 1'b1;
    clear_mon();
    push(10'h0AA);
    wait_idle(2000, "tmo_next_idle");
    check("tmo_next_nstart", 32'(n_start), 32'(1));
    check("tmo_next_din", log_at(0), 32'h0AA);
    check("tmo_next_cslow", 32'(cs_low), 32'(FRAME_LEN));
    check("tmo_sticky", 32'(timeout), 32'(1));
    pulse_clr();
    check("tmo_clr", 32'(timeout), 32'(0));

    // Push in the same cycle as a pop keeps level at 3
    clear_mon();
    push(10'h001);
    wait_cs(1'b0, "pp_cs_low");
    push(10'h201);
    push(10'h202);
    push(10'h203);
    check("pp_level3", 32'(level), 32'(3));
    wait_cs(1'b1, "pp_cs_high");
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = 10'h204;
    @(negedge clk);
    wr_en = 1'b0;
    check("pp_start", 32'(spi_start), 32'(1));
    check("pp_din", 32'(spi_din), 32'h201);
    check("pp_level", 32'(level), 32'(3));
    wait_idle(200, "pp_idle");
    check("pp_nstart", 32'(n_start), 32'(5));
    check("pp_last", log_at(4), 32'h204);

    // Asynchronous reset during WAIT_HIGH with 5 words queued
    clear_mon();
    push(10'h0C3);
    wait_cs(1'b0, "mid_cs_low");
    for (int i = 0; i < 5; i++) push(10'(16 + i));
    check("mid_level5", 32'(level), 32'(5));
    repeat (10) @(negedge clk);
    #2;
    reset  = 1'b0;
    drv_en = 1'b0;
    #1;
    check_reset_vals("mid");
    @(negedge clk);
    reset = 1'b1;
    clear_mon();
    repeat (20) @(negedge clk);
    check("mid_quiet_nstart", 32'(n_start), 32'(0));
    check("mid_quiet_busy", 32'(busy), 32'(0));
    push(10'h2AA);
    wait_idle(100, "mid_new_idle");
    check("mid_new_nstart", 32'(n_start), 32'(1));
    check("mid_new_din", log_at(0), 32'h2AA);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
